// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline constants used by the register file and its read-port muxes.
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NREGS     = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_bypass_mux.sv
// One decode read port: forwards the in-flight writeback data when its index
// matches the committing write, otherwise passes the stored array value.
module rf_bypass_mux
  import rv32_pkg::*;
#(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                 i_commit,
  input  logic [REG_IDX_W-1:0] i_wr_idx,
  input  logic [XLEN-1:0]      i_wr_data,
  input  logic [REG_IDX_W-1:0] i_rd_idx,
  input  logic [XLEN-1:0]      i_arr_data,
  output logic [XLEN-1:0]      o_rd_data
);

  logic w_hit;

  // i_commit is already qualified with rd != x0 and reset, so x0 can never hit.
  assign w_hit     = BYPASS_EN && i_commit && (i_rd_idx == i_wr_idx);
  assign o_rd_data = w_hit ? i_wr_data : i_arr_data;

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural integer register file at the writeback/decode boundary:
// one write port, two bypassed decode read ports, one debug read port, retired-write counter.
module regfile_wb_sink
  import rv32_pkg::*;
#(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter int NREGS     = rv32_pkg::NREGS,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_WB_reg_write,
  input  logic [REG_IDX_W-1:0] MEM_WB_rd,
  input  logic [XLEN-1:0]      RF_WR_Data,
  input  logic [REG_IDX_W-1:0] ID_rs1,
  input  logic [REG_IDX_W-1:0] ID_rs2,
  output logic [XLEN-1:0]      RF_rs1_data,
  output logic [XLEN-1:0]      RF_rs2_data,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  input  logic                 wb_cnt_clr,
  output logic [CNT_W-1:0]     wb_cnt
);

  // x0 has no storage; the array starts at x1.
  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [CNT_W-1:0] r_wb_cnt;

  logic             w_commit;
  logic [XLEN-1:0]  w_arr_rs1;
  logic [XLEN-1:0]  w_arr_rs2;
  logic [XLEN-1:0]  w_arr_dbg;

  // The enable gates the index compare, so an unknown rd with enable low cannot commit.
  assign w_commit = !rst && MEM_WB_reg_write && (MEM_WB_rd != ZERO_REG);

  // NOTE: the register array is reset explicitly because architectural state must read 0
  // the moment rst rises; this is deliberate and keeps it out of plain RAM inference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of process ordering.
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[MEM_WB_rd] <= RF_WR_Data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_cnt <= '0;
    end else if (wb_cnt_clr) begin
      r_wb_cnt <= '0;
    end else if (w_commit) begin
      r_wb_cnt <= r_wb_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through it can hold a previous value and infer a latch.
  always_comb begin
    w_arr_rs1 = '0;
    w_arr_rs2 = '0;
    w_arr_dbg = '0;
    if (ID_rs1   != ZERO_REG) w_arr_rs1 = r_regs[ID_rs1];
    if (ID_rs2   != ZERO_REG) w_arr_rs2 = r_regs[ID_rs2];
    if (dbg_addr != ZERO_REG) w_arr_dbg = r_regs[dbg_addr];
  end

  rf_bypass_mux #(
    .XLEN      (XLEN),
    .BYPASS_EN (BYPASS_EN)
  ) u_rs1_mux (
    .i_commit   (w_commit),
    .i_wr_idx   (MEM_WB_rd),
    .i_wr_data  (RF_WR_Data),
    .i_rd_idx   (ID_rs1),
    .i_arr_data (w_arr_rs1),
    .o_rd_data  (RF_rs1_data)
  );

  rf_bypass_mux #(
    .XLEN      (XLEN),
    .BYPASS_EN (BYPASS_EN)
  ) u_rs2_mux (
    .i_commit   (w_commit),
    .i_wr_idx   (MEM_WB_rd),
    .i_wr_data  (RF_WR_Data),
    .i_rd_idx   (ID_rs2),
    .i_arr_data (w_arr_rs2),
    .o_rd_data  (RF_rs2_data)
  );

  // Debug port observes committed state only, never the in-flight write.
  assign dbg_data = w_arr_dbg;
  assign wb_cnt   = r_wb_cnt;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Self-checking bench: a bypassed 32-bit-counter instance and a non-bypassed
// 4-bit-counter instance share one stimulus stream, checked against an array model.
module tb_regfile_wb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [4:0]  rs1, rs2, dbg;
  logic        clr;

  logic [31:0] a_rs1, a_rs2, a_dbg, a_cnt;
  logic [31:0] b_rs1, b_rs2, b_dbg;
  logic [3:0]  b_cnt;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .MEM_WB_reg_write(we), .MEM_WB_rd(rd), .RF_WR_Data(wdata),
    .ID_rs1(rs1), .ID_rs2(rs2), .RF_rs1_data(a_rs1), .RF_rs2_data(a_rs2),
    .dbg_addr(dbg), .dbg_data(a_dbg), .wb_cnt_clr(clr), .wb_cnt(a_cnt)
  );

  regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0), .CNT_W(4)) dut_nb (
    .clk(clk), .rst(rst), .MEM_WB_reg_write(we), .MEM_WB_rd(rd), .RF_WR_Data(wdata),
    .ID_rs1(rs1), .ID_rs2(rs2), .RF_rs1_data(b_rs1), .RF_rs2_data(b_rs2),
    .dbg_addr(dbg), .dbg_data(b_dbg), .wb_cnt_clr(clr), .wb_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic i_we, input logic [4:0] i_rd, input logic [31:0] i_data,
                       input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                       input logic [4:0] i_dbg, input logic i_clr);
    we = i_we; rd = i_rd; wdata = i_data;
    rs1 = i_rs1; rs2 = i_rs2; dbg = i_dbg; clr = i_clr;
  endtask

  // Expected read value: the write about to commit wins when bypass is on.
  function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && !rst && we && rd != 5'd0 && rd == idx) return wdata;
    return m_regs[idx];
  endfunction

  task automatic model_check();
    check("a_rs1", a_rs1, expect_rd(rs1, 1'b1));
    check("a_rs2", a_rs2, expect_rd(rs2, 1'b1));
    check("a_dbg", a_dbg, expect_rd(dbg, 1'b0));
    check("a_cnt", a_cnt, m_cnt);
    check("b_rs1", b_rs1, expect_rd(rs1, 1'b0));
    check("b_rs2", b_rs2, expect_rd(rs2, 1'b0));
    check("b_dbg", b_dbg, expect_rd(dbg, 1'b0));
    check("b_cnt", {28'h0, b_cnt}, m_cnt & 32'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (we && rd != 5'd0) m_regs[rd] = wdata;
      if (clr) m_cnt = 0;
      else if (we && rd != 5'd0) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic step(input logic i_we, input logic [4:0] i_rd, input logic [31:0] i_data,
                      input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                      input logic [4:0] i_dbg, input logic i_clr);
    drive(i_we, i_rd, i_data, i_rs1, i_rs2, i_dbg, i_clr);
    #3;
    model_check();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4, 5'd4, 1'b0);
    #2;
    check("por_rs1", a_rs1, 32'h0);
    check("por_cnt", a_cnt, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Reset asserted mid-cycle clears state without a clock edge.
    step(1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 1'b0);
    #2;
    check("pre_rst_x5", a_rs1, 32'h1234_5678);
    rst = 1'b1;
    #1;
    check("rst_rs1", a_rs1, 32'h0);
    check("rst_dbg", a_dbg, 32'h0);
    check("rst_cnt", a_cnt, 32'h0);
    check("rst_nb_rs1", b_rs1, 32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
    #1;
    rst = 1'b0;
    tick();

    // Basic write then read on all ports.
    step(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0);
    #3;
    check("wr_rs1", a_rs1, 32'hDEAD_BEEF);
    check("wr_rs2", a_rs2, 32'hDEAD_BEEF);
    check("wr_dbg", a_dbg, 32'hDEAD_BEEF);
    check("wr_cnt", a_cnt, 32'd1);
    tick();

    // Same-cycle bypass versus array-only read.
    step(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3, 1'b0);
    #3;
    check("byp_rs1", a_rs1, 32'h22);
    check("byp_rs2", a_rs2, 32'h22);
    check("byp_dbg", a_dbg, 32'h11);
    check("nobyp_rs1", b_rs1, 32'h11);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3, 1'b0);
    #3;
    check("nobyp_next", b_rs1, 32'h22);
    check("dbg_next", a_dbg, 32'h22);
    tick();

    // Writes to x0 are dropped and not counted.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    check("x0_same", a_rs1, 32'h0);
    check("x0_cnt", a_cnt, 32'd3);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    check("x0_next", a_rs1, 32'h0);
    check("x0_cnt2", a_cnt, 32'd3);
    tick();

    // Bring the 4-bit counter to 15, then wrap.
    for (int i = 0; i < 12; i++)
      step(1'b1, 5'(10 + i % 5), $urandom, 5'(10 + i % 3), 5'd0, 5'd3, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    check("cnt4_full", {28'h0, b_cnt}, 32'd15);
    tick();
    step(1'b1, 5'd20, 32'hA5A5_0001, 5'd20, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    check("cnt4_wrap", {28'h0, b_cnt}, 32'd0);
    check("cnt32_16", a_cnt, 32'd16);
    tick();

    // Clear wins over a same-cycle write, which still commits.
    step(1'b1, 5'd9, 32'h5, 5'd0, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9, 1'b0);
    #3;
    check("clr_cnt", a_cnt, 32'd0);
    check("clr_nb_cnt", {28'h0, b_cnt}, 32'd0);
    check("clr_x9", a_rs1, 32'h5);
    tick();

    // Random stream; reads often target the index being written.
    for (int i = 0; i < 1000; i++) begin
      logic        r_we;
      logic [4:0]  r_rd, r_rs1, r_rs2;
      r_we  = ($urandom_range(0, 3) != 0);
      r_rd  = 5'($urandom_range(0, 31));
      r_rs1 = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_rs2 = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      step(r_we, r_we ? r_rd : 5'bxxxxx, $urandom, r_rs1, r_rs2,
           5'($urandom_range(0, 31)), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Consumer end of the writeback interface: it accepts the rd index, write enable and write data driven by the writeback stage and commits them to the architectural integer register file.
- It serves two combinational read ports for decode, with same-cycle write-to-read bypass, plus one debug/trap read port.
- A retired-write counter supports trap and diagnostic logic.
- It sits between the writeback stage and the decode stage of the RV32I pipeline.

Parameters:
XLEN, 32, register data width
NREGS, 32, architectural register count (index width = clog2(NREGS) = 5)
BYPASS_EN, 1, 1 = write-to-read bypass on the read ports; 0 = read array only
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
MEM_WB_reg_write  input  1  write enable from writeback
MEM_WB_rd  input  5  destination register index from writeback
RF_WR_Data  input  XLEN  write data from writeback
ID_rs1  input  5  decode read index A
ID_rs2  input  5  decode read index B
RF_rs1_data  output  XLEN  read data A
RF_rs2_data  output  XLEN  read data B
dbg_addr  input  5  debug/trap read index
dbg_data  output  XLEN  debug read data (array only, never bypassed)
wb_cnt_clr  input  1  synchronous clear of the retired-write counter
wb_cnt  output  CNT_W  count of committed writes to x1..x31

Behaviour:
- Reset (asynchronous, active-high): registers x1..x31 clear to 0 and wb_cnt clears to 0, both immediately on rst assertion, independent of clk. Read outputs therefore show 0 for every index during reset. Writes are ignored while rst=1.
- x0: there is no storage for x0. A read of index 0 returns 0 on every port. A write with MEM_WB_rd=0 is dropped and does not count.
- Commit: on a rising clk edge with rst=0, MEM_WB_reg_write=1 and MEM_WB_rd!=0, the array entry [MEM_WB_rd] takes RF_WR_Data. Write latency is 1 cycle to the array.
- Read ports: fully combinational, zero latency.
  - With BYPASS_EN=1, when MEM_WB_reg_write=1, MEM_WB_rd!=0 and ID_rsN==MEM_WB_rd, RF_rsN_data = RF_WR_Data in the same cycle. This is write-first.
  - Otherwise RF_rsN_data = array[ID_rsN].
  - Both ports may hit the bypass on the same index at once; both then return the same value.
- With BYPASS_EN=0: a same-cycle read returns the old value, and the new value is visible the cycle after the edge.
- dbg_data = array[dbg_addr]; it is 0 for index 0 and is never bypassed.
- Counter:
  - On each clk edge with a committed write (enable=1, rd!=0), wb_cnt increments by 1.
  - Wrap-around is modulo 2^CNT_W, with no saturation and no flag.
  - wb_cnt_clr=1 has priority over an increment in the same cycle: the result is 0, and that cycle's write is not counted.
- Write data is XLEN bits, stored without modification; there is no sign or width conversion.
- Unknown (X) on MEM_WB_rd while enable=0 must not corrupt the array. The write decode is gated by the enable.

Decomposition:
- Shared package (rv32_pkg): XLEN, REG_IDX_W=5, NREGS, and the constant ZERO_REG=5'd0.
- One natural sub-module, rf_bypass_mux: the per-port compare and select between write data and array data. It is instantiated twice, once per read port.
- The storage array and counter stay in the top module.

Test Plan:
1. Reset: assert rst mid-simulation after writing x5=0x12345678 → RF_rs1_data with ID_rs1=5 reads 0 immediately (before the next clk edge), and wb_cnt=0.
2. Basic write/read: write x7=0xDEADBEEF, then on the next cycle read with ID_rs1=7, ID_rs2=7 → both ports 0xDEADBEEF; dbg_addr=7 → 0xDEADBEEF; wb_cnt=1.
3. Same-cycle bypass: x3 holds 0x11. In one cycle drive write x3=0x22 with ID_rs1=3 → RF_rs1_data=0x22 in that cycle (BYPASS_EN=1), while dbg_data for index 3 shows 0x11 until the edge. With BYPASS_EN=0 the same stimulus gives RF_rs1_data=0x11.
4. x0 protection: write rd=0, data 0xFFFFFFFF, with ID_rs1=0 → RF_rs1_data=0 in the same and next cycle; wb_cnt unchanged.
5. Counter edges: preload by performing 2^CNT_W−1 writes (or use a reduced CNT_W=4 instance with 15 writes) → the next write wraps wb_cnt to 0. Drive wb_cnt_clr together with a write to x9=0x5 → wb_cnt=0 and x9=0x5.
6. Randomised write/read stream (1000 cycles, random rd/rs/data) against a reference model → every read port matches model-with-bypass, and wb_cnt equals the count of enable=1, rd!=0 writes since the last clear.
